// File: rtl/seq_digit_adder_pkg.sv
// Shared types and helpers for the digit-serial adder: FSM encoding and
// counter sizing.
package seq_digit_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter width for n digits; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_digit_adder_digit_adder.sv
// Combinational DIGIT-bit ripple-carry slice; also exposes the carry into
// the MSB so the caller can derive signed overflow.
module digit_adder #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             cin_i,
  output logic [DIGIT-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  always_comb begin
    logic [DIGIT:0] c;
    c     = '0;
    sum_o = '0;
    c[0]  = cin_i;
    for (int i = 0; i < int'(DIGIT); i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = c[DIGIT];
    cmsb_o = c[DIGIT-1];
  end

endmodule

// File: rtl/seq_digit_adder.sv
// Digit-serial add/subtract: one DIGIT-wide slice reused NUM_DIGITS times,
// carry chained through a flop, valid/ready on both sides.
module seq_digit_adder
  import seq_digit_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NUM_DIGITS = WIDTH / DIGIT;
  localparam int unsigned CNT_W      = cnt_width(NUM_DIGITS);

  if ((WIDTH % DIGIT) != 0 || NUM_DIGITS < 1) begin : g_param_chk
    $fatal(1, "seq_digit_adder: WIDTH must be a non-zero multiple of DIGIT");
  end

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  int unsigned        idx;
  logic [DIGIT-1:0]   slice_a, slice_b, slice_sum;
  logic               slice_cout, slice_cmsb;
  logic               last_digit;

  // Select the current digit of each operand.
  always_comb begin
    idx     = 32'(cnt_q) * DIGIT;
    slice_a = opa_q[idx +: DIGIT];
    slice_b = opb_q[idx +: DIGIT];
  end

  assign last_digit = (cnt_q == CNT_W'(NUM_DIGITS - 1));

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout),
    .cmsb_o (slice_cmsb)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          opa_d   = a;
          // Subtraction is a + ~b + 1: invert b here, inject the +1 as carry.
          opb_d   = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[idx +: DIGIT] = slice_sum;
        carry_d             = slice_cout;
        cnt_d               = cnt_q + CNT_W'(1);
        if (last_digit) begin
          cout_d  = slice_cout;
          ovf_d   = slice_cmsb ^ slice_cout;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_digit_adder.sv
// Bench for seq_digit_adder: three configurations (16/4, 8/2, 8/8) checked
// against fixed vectors and an arithmetic reference model.
module tb_seq_digit_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        iv[3];
  logic        orr[3];
  logic        cinv[3];
  logic        subv[3];
  logic [15:0] av[3];
  logic [15:0] bv[3];

  logic        ir0, ov0, co0, of0;
  logic        ir1, ov1, co1, of1;
  logic        ir2, ov2, co2, of2;
  logic [15:0] s0;
  logic [7:0]  s1, s2;

  int checks = 0;
  int errors = 0;

  int unsigned wv[3] = '{16, 8, 8};
  int unsigned nd[3] = '{4, 4, 1};

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    int          stall;
    logic [15:0] esum;
    logic        ecout;
    logic        eovf;
  } vec_t;

  always #5 clk = ~clk;

  seq_digit_adder #(.WIDTH(16), .DIGIT(4)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir0),
    .a(av[0]), .b(bv[0]), .cin(cinv[0]), .sub(subv[0]),
    .out_valid(ov0), .out_ready(orr[0]), .sum(s0), .cout(co0), .ovf(of0)
  );

  seq_digit_adder #(.WIDTH(8), .DIGIT(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir1),
    .a(av[1][7:0]), .b(bv[1][7:0]), .cin(cinv[1]), .sub(subv[1]),
    .out_valid(ov1), .out_ready(orr[1]), .sum(s1), .cout(co1), .ovf(of1)
  );

  seq_digit_adder #(.WIDTH(8), .DIGIT(8)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir2),
    .a(av[2][7:0]), .b(bv[2][7:0]), .cin(cinv[2]), .sub(subv[2]),
    .out_valid(ov2), .out_ready(orr[2]), .sum(s2), .cout(co2), .ovf(of2)
  );

  // {in_ready, out_valid, cout, ovf, sum} of one instance
  function automatic logic [19:0] obs(input int k);
    case (k)
      0:       return {ir0, ov0, co0, of0, s0};
      1:       return {ir1, ov1, co1, of1, 8'h00, s1};
      default: return {ir2, ov2, co2, of2, 8'h00, s2};
    endcase
  endfunction

  // Reference: {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [17:0] model(input int w, input logic [15:0] a,
                                        input logic [15:0] b, input logic cin,
                                        input logic sub);
    longint m, ua, ub, full, sa, sb, res;
    logic   o, c;
    m    = longint'(1) << w;
    ua   = longint'(a) & (m - 1);
    ub   = longint'(b) & (m - 1);
    full = sub ? (ua - ub + m) : (ua + ub + longint'(cin));
    sa   = (ua >= m / 2) ? ua - m : ua;
    sb   = (ub >= m / 2) ? ub - m : ub;
    res  = sub ? (sa - sb) : (sa + sb + longint'(cin));
    o    = (res >= m / 2) || (res < -(m / 2));
    c    = ((full >> w) & 1) != 0;
    return {o, c, 16'(full % m)};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub, input int stall,
                        input logic [17:0] exp, input string name);
    int n;
    logic [19:0] snap;
    @(negedge clk);
    n = 0;
    while (!obs(k)[19] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, " in_ready"}, 32'(obs(k)[19]), 32'd1);
    iv[k] = 1'b1; av[k] = a; bv[k] = b; cinv[k] = cin; subv[k] = sub;
    orr[k] = 1'b0;
    @(posedge clk);
    #1;
    iv[k] = 1'b0;
    chk({name, " busy"}, 32'(obs(k)[19:18]), 32'd0);
    n = 0;
    while (!obs(k)[18] && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, " latency"}, 32'(n), 32'(nd[k]));
    chk({name, " result"}, 32'({obs(k)[16], obs(k)[17], obs(k)[15:0]}), 32'(exp));
    snap = obs(k);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk({name, " hold"}, 32'(obs(k)), 32'(snap));
    end
    orr[k] = 1'b1;
    @(posedge clk);
    #1;
    orr[k] = 1'b0;
    chk({name, " release"}, 32'(obs(k)[19:18]), 32'b10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[7];
    logic [15:0] ra, rb, mask;
    logic        rc, rs;
    int          nops;

    vt[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 0, 16'h5555, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 0, 16'h8000, 1'b0, 1'b1};
    vt[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 5, 16'hFFFE, 1'b0, 1'b0};
    vt[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 2, 16'h7FFF, 1'b1, 1'b1};
    vt[5] = '{16'h1234, 16'h0000, 1'b1, 1'b1, 0, 16'h1234, 1'b1, 1'b0};
    vt[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 3, 16'hFFFF, 1'b1, 1'b0};

    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; orr[k] = 1'b0; cinv[k] = 1'b0; subv[k] = 1'b0;
      av[k] = '0; bv[k] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("reset state u%0d", k), 32'(obs(k)), 32'({4'b1000, 16'h0}));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i])
      run_op(0, vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, vt[i].stall,
             {vt[i].eovf, vt[i].ecout, vt[i].esum}, $sformatf("vec%0d", i));

    // Asynchronous reset two digits into an operation.
    @(negedge clk);
    iv[0] = 1'b1; av[0] = 16'h1111; bv[0] = 16'h1111; cinv[0] = 1'b0; subv[0] = 1'b0;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("partial sum before reset", 32'(s0[7:0]), 32'h22);
    rst_n = 1'b0;
    #1;
    chk("reset mid-run", 32'(obs(0)), 32'({4'b1000, 16'h0}));
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0, 0, 18'h00002, "after reset");

    // Randomised operands with corner-value bias and random stalls.
    for (int k = 0; k < 3; k++) begin
      mask = 16'((32'd1 << wv[k]) - 1);
      nops = (k == 0) ? 120 : 300;
      for (int n = 0; n < nops; n++) begin
        case ($urandom_range(0, 3))
          0:       ra = '0;
          1:       ra = mask;
          2:       ra = 16'(32'd1 << (wv[k] - 1));
          default: ra = 16'($urandom);
        endcase
        rb = ($urandom_range(0, 3) == 0) ? mask : 16'($urandom);
        if ($urandom_range(0, 5) == 0) rb = '0;
        ra = ra & mask;
        rb = rb & mask;
        rc = 1'($urandom);
        rs = 1'($urandom);
        run_op(k, ra, rb, rc, rs, $urandom_range(0, 3),
               model(int'(wv[k]), ra, rb, rc, rs),
               $sformatf("rand u%0d a=%h b=%h c=%0d s=%0d", k, ra, rb, rc, rs));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
